// File: rtl/param_serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a start/done handshake.
// Produces a WIDTH-bit difference and a borrow-out that appear only at completion.
module param_serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             d_bit;
    logic             br_nx;
    logic [WIDTH:0]   res_ext;

    // Next-state, handshake decode and the single-bit subtract slice
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (cnt == CW'(WIDTH - 1));
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_ext  = {d_bit, res};
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand shifters, borrow flop, bit counter and MSB-in result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            res  <= res_ext[WIDTH:1];
            br   <= br_nx;
            cnt  <= cnt + CW'(1);
        end
    end

    // Outputs: d/bout load only on the edge that completes the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
        end else begin
            busy <= (state_nx == S_RUN);
            done <= (state_nx == S_DONE);
            if ((state == S_RUN) && last) begin
                d    <= res_ext[WIDTH:1];
                bout <= br_nx;
            end
        end
    end

endmodule

// File: tb/tb_param_serial_subtractor.sv
// Bench for param_serial_subtractor at WIDTH 4, 8 and 1: directed vectors with
// literal expectations plus a cycle-level arithmetic model checked every cycle.
module tb_param_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       st  [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] ta  [3] = '{8'd0, 8'd0, 8'd0};
    logic [7:0] tbv [3] = '{8'd0, 8'd0, 8'd0};
    logic       bsy [3];
    logic       dn  [3];
    logic       bo  [3];
    logic [7:0] dd  [3];
    logic [3:0] d4;
    logic [7:0] d8;
    logic [0:0] d1;

    int total = 0;
    int bad   = 0;

    // Model state: remaining RUN cycles, latched operands, expected outputs
    int         left  [3] = '{0, 0, 0};
    logic [7:0] la    [3] = '{8'd0, 8'd0, 8'd0};
    logic [7:0] lb    [3] = '{8'd0, 8'd0, 8'd0};
    logic [7:0] md    [3] = '{8'd0, 8'd0, 8'd0};
    logic       mb    [3] = '{1'b0, 1'b0, 1'b0};
    logic       mdone [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    param_serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ta[0][3:0]), .b(tbv[0][3:0]),
        .busy(bsy[0]), .done(dn[0]), .d(d4), .bout(bo[0]));
    param_serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ta[1]), .b(tbv[1]),
        .busy(bsy[1]), .done(dn[1]), .d(d8), .bout(bo[1]));
    param_serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(ta[2][0:0]), .b(tbv[2][0:0]),
        .busy(bsy[2]), .done(dn[2]), .d(d1), .bout(bo[2]));

    assign dd[0] = {4'b0, d4};
    assign dd[1] = d8;
    assign dd[2] = {7'b0, d1};

    function automatic int wid(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 1);
    endfunction

    function automatic logic [7:0] msk(input int k);
        return 8'((9'd1 << wid(k)) - 9'd1);
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s w=%0d got=%0d want=%0d t=%0t", nm, wid(k), act, exp, $time);
        end
    endtask

    // Model: an accepted op completes exactly WIDTH edges later with plain subtraction
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                left[k]  = 0;
                md[k]    = 8'd0;
                mb[k]    = 1'b0;
                mdone[k] = 1'b0;
            end else begin
                mdone[k] = 1'b0;
                if (left[k] > 0) begin
                    left[k] = left[k] - 1;
                    if (left[k] == 0) begin
                        logic [8:0] diff;
                        diff     = {1'b0, la[k]} - {1'b0, lb[k]};
                        md[k]    = diff[7:0] & msk(k);
                        mb[k]    = (la[k] < lb[k]);
                        mdone[k] = 1'b1;
                    end
                end else if (st[k]) begin
                    la[k]   = ta[k] & msk(k);
                    lb[k]   = tbv[k] & msk(k);
                    left[k] = wid(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, int'(bsy[k]), int'(left[k] > 0));
            chk("done", k, int'(dn[k]), int'(mdone[k]));
            chk("d", k, int'(dd[k]), int'(md[k]));
            chk("bout", k, int'(bo[k]), int'(mb[k]));
            if (bsy[k] && dn[k]) chk("busy_and_done", k, 1, 0);
        end
    end

    task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv);
        st[k]  = 1'b1;
        ta[k]  = av;
        tbv[k] = bv;
        @(negedge clk);
        st[k]  = 1'b0;
        ta[k]  = ~av;
        tbv[k] = ~bv;
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!dn[k] && n < wid(k) + 3) begin
            @(negedge clk);
            n++;
        end
        if (!dn[k]) begin
            total++;
            bad++;
            $display("FAIL done_timeout w=%0d got=no_done want=done t=%0t", wid(k), $time);
        end
    endtask

    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          output int n);
        issue(k, av, bv);
        wait_done(k, n);
    endtask

    initial begin
        int n;
        int pulses;
        int prev;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 0, int'(bsy[0]), 0);
        chk("rst_done", 0, int'(dn[0]), 0);
        chk("rst_d", 0, int'(d4), 0);
        chk("rst_bout", 0, int'(bo[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 8'd5, 8'd3, n);
        chk("lat_5_3", 0, n, 4);
        chk("d_5_3", 0, int'(d4), 2);
        chk("bout_5_3", 0, int'(bo[0]), 0);
        run_op(0, 8'd3, 8'd5, n);
        chk("d_3_5", 0, int'(d4), 14);
        chk("bout_3_5", 0, int'(bo[0]), 1);
        run_op(0, 8'd0, 8'd1, n);
        chk("d_0_1", 0, int'(d4), 15);
        chk("bout_0_1", 0, int'(bo[0]), 1);
        run_op(0, 8'd15, 8'd15, n);
        chk("d_15_15", 0, int'(d4), 0);
        chk("bout_15_15", 0, int'(bo[0]), 0);

        // start held high: a result every WIDTH+1 cycles
        st[0] = 1'b1; ta[0] = 8'd15; tbv[0] = 8'd1;
        pulses = 0;
        prev = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (dn[0]) begin
                pulses++;
                chk("bb_gap", 0, i - prev, 5);
                chk("bb_d", 0, int'(d4), 14);
                prev = i;
            end
        end
        st[0] = 1'b0;
        chk("bb_pulses", 0, pulses, 3);
        @(negedge clk);

        // start during RUN is ignored
        issue(0, 8'd9, 8'd2);
        @(negedge clk);
        st[0] = 1'b1; ta[0] = 8'd0; tbv[0] = 8'd7;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, n);
        chk("ign_lat", 0, n + 2, 4);
        chk("ign_d", 0, int'(d4), 7);
        chk("ign_bout", 0, int'(bo[0]), 0);

        // reset mid-RUN aborts with outputs cleared at once
        issue(0, 8'd6, 8'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, int'(bsy[0]), 0);
        chk("abort_done", 0, int'(dn[0]), 0);
        chk("abort_d", 0, int'(d4), 0);
        chk("abort_bout", 0, int'(bo[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (dn[0]) pulses++;
        end
        chk("abort_no_done", 0, pulses, 0);
        run_op(0, 8'd6, 8'd1, n);
        chk("after_abort_d", 0, int'(d4), 5);

        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                run_op(2, 8'(x), 8'(y), n);
                chk("lat_w1", 2, n, 1);
            end
        end
        run_op(2, 8'd0, 8'd1, n);
        chk("w1_d", 2, int'(d1), 1);
        chk("w1_bout", 2, int'(bo[2]), 1);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(0, 8'(x), 8'(y), n);
                chk("lat_w4", 0, n, 4);
            end
        end

        for (int x = 0; x < 256; x += 17) begin
            for (int y = 0; y < 256; y++) begin
                run_op(1, 8'(x), 8'(y), n);
                chk("lat_w8", 1, n, 8);
            end
        end
        run_op(1, 8'd16, 8'd200, n);
        chk("w8_d", 1, int'(d8), 72);
        chk("w8_bout", 1, int'(bo[1]), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
